// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with a 2-entry skid buffer, flush and control-bubble masking.
// Optional stall/bubble counters are built when PIPE_STAGE_SKID_STATS_EN is defined.
module pipe_stage_skid #(
  parameter int                DATA_W   = 96,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl
`ifdef PIPE_STAGE_SKID_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       bubble_cycles
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic              upReady_q;
  logic [DATA_W-1:0] mData_q, sData_q;
  logic [CTRL_W-1:0] mCtrl_q, sCtrl_q;

  logic mValid, inXfer, outXfer;
  logic loadMainUp, loadMainSkid, loadSkid;

  assign mValid  = (state_q != EMPTY);
  assign inXfer  = up_valid & upReady_q;
  assign outXfer = mValid & dn_ready;

  always_comb begin
    state_d      = state_q;
    loadMainUp   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (inXfer) begin
          loadMainUp = 1'b1;
          state_d    = FULL;
        end
      end
      FULL: begin
        if (inXfer && outXfer) begin
          loadMainUp = 1'b1;
        end else if (inXfer) begin
          loadSkid = 1'b1;
          state_d  = SKID;
        end else if (outXfer) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        // Upstream is blocked here, so only the drain path can fire.
        if (outXfer) begin
          loadMainSkid = 1'b1;
          state_d      = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops held and incoming entries but leaves the data registers untouched.
    if (flush) begin
      state_d      = EMPTY;
      loadMainUp   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      upReady_q <= 1'b1;
      mData_q   <= '0;
      mCtrl_q   <= CTRL_RST;
      sData_q   <= '0;
      sCtrl_q   <= CTRL_RST;
    end else begin
      state_q   <= state_d;
      upReady_q <= (state_d != SKID);
      if (loadMainUp) begin
        mData_q <= up_data;
        mCtrl_q <= up_ctrl;
      end else if (loadMainSkid) begin
        mData_q <= sData_q;
        mCtrl_q <= sCtrl_q;
      end
      if (loadSkid) begin
        sData_q <= up_data;
        sCtrl_q <= up_ctrl;
      end
    end
  end

  assign up_ready = upReady_q;
  assign dn_valid = mValid;
  assign dn_data  = mData_q;
  assign dn_ctrl  = mValid ? mCtrl_q : CTRL_RST;

`ifdef PIPE_STAGE_SKID_STATS_EN
  logic [31:0] stallCnt_q, bubbleCnt_q;

  // Counters saturate rather than wrap; clear wins over increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
    end else if (stats_clr) begin
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
    end else begin
      if (mValid && !dn_ready && (stallCnt_q != 32'hFFFF_FFFF)) begin
        stallCnt_q <= stallCnt_q + 32'd1;
      end
      if (!mValid && (bubbleCnt_q != 32'hFFFF_FFFF)) begin
        bubbleCnt_q <= bubbleCnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles  = stallCnt_q;
  assign bubble_cycles = bubbleCnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int                DATA_W   = 96;
  localparam int                CTRL_W   = 16;
  localparam logic [CTRL_W-1:0] CTRL_RST = '0;

  logic              clock = 1'b0;
  logic              reset, flush, upValid, upReady, dnValid, dnReady;
  logic [DATA_W-1:0] upData, dnData;
  logic [CTRL_W-1:0] upCtrl, dnCtrl;
`ifdef PIPE_STAGE_SKID_STATS_EN
  logic              statsClr;
  logic [31:0]       stallCycles, bubbleCycles;
`endif

  int total = 0;
  int bad   = 0;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .up_valid (upValid),
    .up_ready (upReady),
    .up_data  (upData),
    .up_ctrl  (upCtrl),
    .dn_valid (dnValid),
    .dn_ready (dnReady),
    .dn_data  (dnData),
    .dn_ctrl  (dnCtrl)
`ifdef PIPE_STAGE_SKID_STATS_EN
    ,
    .stats_clr     (statsClr),
    .stall_cycles  (stallCycles),
    .bubble_cycles (bubbleCycles)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: the stage is a FIFO of depth two; the output shows the head,
  // and the payload of the last head seen stays visible once the FIFO drains.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t            modelQ[$];
  logic [DATA_W-1:0] modelLast;

  function automatic void modelReset();
    modelQ.delete();
    modelLast = '0;
  endfunction

  function automatic void modelStep(input logic f, input logic uv, input logic [DATA_W-1:0] d,
                                    input logic [CTRL_W-1:0] c, input logic dr);
    entry_t e;
    bit inX, outX;
    inX  = uv && (modelQ.size() < 2);
    outX = (modelQ.size() > 0) && dr;
    if (outX) void'(modelQ.pop_front());
    if (f) begin
      modelQ.delete();
    end else if (inX) begin
      e.data = d;
      e.ctrl = c;
      modelQ.push_back(e);
    end
    if (modelQ.size() > 0) modelLast = modelQ[0].data;
  endfunction

  // Drives one cycle of inputs at the falling edge, advances the model at the
  // rising edge and returns at the next falling edge with outputs settled.
  task automatic applyStimulus(input logic f, input logic uv, input logic [DATA_W-1:0] d,
                               input logic [CTRL_W-1:0] c, input logic dr);
    flush   = f;
    upValid = uv;
    upData  = d;
    upCtrl  = c;
    dnReady = dr;
    @(posedge clock);
    modelStep(f, uv, d, c, dr);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic eV, input logic eR,
                             input logic [DATA_W-1:0] eD, input logic [CTRL_W-1:0] eC);
    total++;
    if (dnValid !== eV || upReady !== eR || dnData !== eD || dnCtrl !== eC) begin
      bad++;
      $display("[TB] FAIL %s: got valid=%b ready=%b data=%h ctrl=%h, want valid=%b ready=%b data=%h ctrl=%h",
               name, dnValid, upReady, dnData, dnCtrl, eV, eR, eD, eC);
    end
  endtask

  task automatic checkModel(input string name);
    logic [CTRL_W-1:0] eC;
    eC = (modelQ.size() > 0) ? modelQ[0].ctrl : CTRL_RST;
    checkOutput(name, modelQ.size() > 0, modelQ.size() < 2, modelLast, eC);
  endtask

  typedef struct {
    logic              f;
    logic              uv;
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic              dr;
    logic              eV;
    logic              eR;
    logic [DATA_W-1:0] eD;
    logic [CTRL_W-1:0] eC;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [DATA_W-1:0] rd;
    logic [CTRL_W-1:0] rc;

    // Expected values are the outputs after the rising edge that consumes the inputs.
    vecs[0]  = '{1'b0, 1'b1, 96'd1,  16'd1,      1'b1, 1'b1, 1'b1, 96'd1,  16'd1};
    vecs[1]  = '{1'b0, 1'b1, 96'd2,  16'd2,      1'b1, 1'b1, 1'b1, 96'd2,  16'd2};
    vecs[2]  = '{1'b0, 1'b1, 96'd3,  16'd3,      1'b1, 1'b1, 1'b1, 96'd3,  16'd3};
    vecs[3]  = '{1'b0, 1'b1, 96'd4,  16'd4,      1'b0, 1'b1, 1'b0, 96'd3,  16'd3};
    vecs[4]  = '{1'b0, 1'b1, 96'd5,  16'd5,      1'b0, 1'b1, 1'b0, 96'd3,  16'd3};
    vecs[5]  = '{1'b0, 1'b0, 96'd0,  16'd0,      1'b1, 1'b1, 1'b1, 96'd4,  16'd4};
    vecs[6]  = '{1'b0, 1'b0, 96'd0,  16'd0,      1'b1, 1'b0, 1'b1, 96'd4,  16'd0};
    vecs[7]  = '{1'b0, 1'b1, 96'd6,  16'hFFFF,   1'b1, 1'b1, 1'b1, 96'd6,  16'hFFFF};
    vecs[8]  = '{1'b0, 1'b0, 96'd0,  16'd0,      1'b1, 1'b0, 1'b1, 96'd6,  16'd0};
    vecs[9]  = '{1'b0, 1'b1, 96'd7,  16'd7,      1'b0, 1'b1, 1'b1, 96'd7,  16'd7};
    vecs[10] = '{1'b0, 1'b1, 96'd8,  16'd8,      1'b0, 1'b1, 1'b0, 96'd7,  16'd7};
    vecs[11] = '{1'b1, 1'b1, 96'd9,  16'd9,      1'b0, 1'b0, 1'b1, 96'd7,  16'd0};
    vecs[12] = '{1'b0, 1'b1, 96'd10, 16'd10,     1'b1, 1'b1, 1'b1, 96'd10, 16'd10};
    vecs[13] = '{1'b1, 1'b0, 96'd0,  16'd0,      1'b1, 1'b0, 1'b1, 96'd10, 16'd0};

    reset   = 1'b1;
    flush   = 1'b0;
    upValid = 1'b0;
    upData  = '0;
    upCtrl  = '0;
    dnReady = 1'b0;
`ifdef PIPE_STAGE_SKID_STATS_EN
    statsClr = 1'b0;
`endif
    modelReset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_state", 1'b0, 1'b1, '0, CTRL_RST);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].f, vecs[i].uv, vecs[i].d, vecs[i].c, vecs[i].dr);
      checkOutput($sformatf("vec%0d", i), vecs[i].eV, vecs[i].eR, vecs[i].eD, vecs[i].eC);
    end

    // Async reset while both entries are occupied.
    applyStimulus(1'b0, 1'b1, 96'hA, 16'hA, 1'b0);
    applyStimulus(1'b0, 1'b1, 96'hB, 16'hB, 1'b0);
    checkOutput("skid_full", 1'b1, 1'b0, 96'hA, 16'hA);
    upValid = 1'b0;
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", 1'b0, 1'b1, '0, CTRL_RST);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 96'h1234_5678_9ABC, 16'h5A5A, 1'b1);
    checkOutput("post_reset_in", 1'b1, 1'b1, 96'h1234_5678_9ABC, 16'h5A5A);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkModel("post_reset_drain");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom, $urandom, $urandom};
      rc = CTRL_W'($urandom);
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, rd, rc,
                    $urandom_range(0, 4) < 3);
      checkModel($sformatf("rand%0d", i));
    end

`ifdef PIPE_STAGE_SKID_STATS_EN
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
    statsClr = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    statsClr = 1'b0;
    applyStimulus(1'b0, 1'b1, 96'h55, 16'h1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    total++;
    if (stallCycles !== 32'd3 || bubbleCycles !== 32'd2) begin
      bad++;
      $display("[TB] FAIL stats_count: got stall=%0d bubble=%0d, want stall=3 bubble=2",
               stallCycles, bubbleCycles);
    end
    statsClr = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    statsClr = 1'b0;
    total++;
    if (stallCycles !== 32'd0 || bubbleCycles !== 32'd0) begin
      bad++;
      $display("[TB] FAIL stats_clear: got stall=%0d bubble=%0d, want stall=0 bubble=0",
               stallCycles, bubbleCycles);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
